shift_add_mul_seq: RTL and testbench

- Sequential 4x4 unsigned shift-and-add multiplier controller.
- Sits directly upstream of the team's combinational 4-bit ripple adder (x, y, cin -> s, cout). It drives the adder operands once per cycle and consumes its sum and carry on the same cycle.
- Produces an 8-bit product using a start/done handshake.
- Serves as the multi-cycle arithmetic stage above the adder in the datapath.

---
 rtl/shift_add_mul_seq_if.sv | 27 ++
 rtl/shift_add_mul_seq.sv | 102 ++++++++++
 tb/tb_shift_add_mul_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mul_seq_if.sv
// Operand/result handshake and adder-side signals of the shift-and-add multiplier.
// slave = multiplier view, master = requester plus combinational adder view.
interface shift_add_mul_seq_if #(
  parameter int DATA_W = 4
);
  logic                  start;
  logic [DATA_W-1:0]     mcand;
  logic [DATA_W-1:0]     mplier;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   product;
  logic [DATA_W-1:0]     add_x;
  logic [DATA_W-1:0]     add_y;
  logic                  add_cin;
  logic [DATA_W-1:0]     add_s;
  logic                  add_cout;

  modport slave (
    input  start, mcand, mplier, add_s, add_cout,
    output busy, done, product, add_x, add_y, add_cin
  );

  modport master (
    output start, mcand, mplier, add_s, add_cout,
    input  busy, done, product, add_x, add_y, add_cin
  );
endinterface

// File: rtl/shift_add_mul_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving an external ripple adder.
// Optional macro ZERO_SKIP_EN: zero operands bypass RUN and complete with product 0.
module shift_add_mul_seq #(
  parameter int DATA_W = 4,
  parameter int ITER_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_mul_seq_if.slave   bus,
  output logic [1:0]           state_dbg
);

  // Handshake: start is accepted in any cycle where state is IDLE or DONE and
  // start=1; operands are captured on that edge. done pulses for one cycle when
  // product becomes valid; product then holds until the next completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   m_q, a_q, q_q;
  logic [ITER_W-1:0]   cnt_q;
  logic [2*DATA_W-1:0] product_q;
  logic                accept;
  logic                skip;
  logic                last;
  logic                busy_c;
  logic                done_c;
  logic [DATA_W-1:0]   add_y_c;
  logic [2*DATA_W-1:0] shifted;

`ifdef ZERO_SKIP_EN
  assign skip = (bus.mcand == '0) || (bus.mplier == '0);
`else
  assign skip = 1'b0;
`endif

  assign last    = (cnt_q == ITER_W'(DATA_W - 1));
  // Right shift of {cout, sum, Q}: the carry lands in A's MSB, sum LSB enters Q.
  assign shifted = {bus.add_cout, bus.add_s, q_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    add_y_c = '0;
    case (state)
      IDLE, DONE: begin
        done_c = (state == DONE);
        if (bus.start) begin
          accept  = 1'b1;
          state_n = skip ? DONE : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (q_q[0]) add_y_c = m_q;
        if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      m_q   <= bus.mcand;
      q_q   <= bus.mplier;
      a_q   <= '0;
      cnt_q <= '0;
      if (skip) product_q <= '0;
    end else if (state == RUN) begin
      {a_q, q_q} <= shifted;
      cnt_q      <= cnt_q + 1'b1;
      if (last) product_q <= shifted;
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.product = product_q;
  assign bus.add_x   = a_q;
  assign bus.add_y   = add_y_c;
  assign bus.add_cin = 1'b0;
  assign state_dbg   = state;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Self-checking bench for shift_add_mul_seq with a behavioural 4-bit adder and
// a product scoreboard popped on every done pulse.
module tb_shift_add_mul_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  shift_add_mul_seq_if #(.DATA_W(4)) bus ();

  shift_add_mul_seq #(.DATA_W(4), .ITER_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Combinational ripple adder sitting below the multiplier.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {4'b0, bus.add_cin};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int pushed   = 0;
  logic cout_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy && bus.add_cout) cout_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'b0, bus.done}, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("product", {24'b0, bus.product}, {24'b0, e});
          check("done_busy_excl", {31'b0, bus.busy}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic drive_start(input logic [3:0] mc, input logic [3:0] mp, input bit push);
    logic [7:0] p;
    p = {4'b0, mc} * {4'b0, mp};
    bus.start  = 1'b1;
    bus.mcand  = mc;
    bus.mplier = mp;
    if (push) begin
      exp_q.push_back(p);
      pushed++;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen; returns at posedge+#1 in the DONE cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int lat;
    int busy_n;
    bit found;
    lat = 99; busy_n = 0; found = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        lat = k; found = 1;
        break;
      end
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

`ifdef ZERO_SKIP_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 4;
  localparam int ZERO_BUSY = 4;
`endif

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mcand  = 4'h0;
    bus.mplier = 4'h0;
    idle_cycles(3);
    check("rst_busy",    {31'b0, bus.busy},    32'd0);
    check("rst_done",    {31'b0, bus.done},    32'd0);
    check("rst_product", {24'b0, bus.product}, 32'd0);
    check("rst_add_x",   {28'b0, bus.add_x},   32'd0);
    check("rst_add_y",   {28'b0, bus.add_y},   32'd0);
    check("rst_add_cin", {31'b0, bus.add_cin}, 32'd0);
    check("rst_state",   {30'b0, state_dbg},   32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic multiply
    drive_start(4'h3, 4'h5, 1);
    wait_done("op_3x5", 4, 4);
    idle_cycles(2);

    // Largest operands; carry-out must be exercised
    cout_seen = 1'b0;
    drive_start(4'hF, 4'hF, 1);
    wait_done("op_fxf", 4, 4);
    check("cout_seen", {31'b0, cout_seen}, 32'd1);
    idle_cycles(1);

    // Back-to-back: start held in DONE accepts the next operands
    drive_start(4'h7, 4'h9, 1);
    wait_done("op_7x9", 4, 4);
    drive_start(4'hA, 4'hC, 1);
    wait_done("op_axc_b2b", 4, 4);
    idle_cycles(2);

    // start and operand changes during RUN are ignored
    d0 = done_cnt;
    drive_start(4'h2, 4'h6, 1);
    bus.start  = 1'b1;
    bus.mcand  = 4'hF;
    bus.mplier = 4'hF;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.mcand  = 4'h1;
    wait_done("op_2x6_ignored_start", 3, 3);
    idle_cycles(3);
    check("single_done", done_cnt - d0, 32'd1);

    // Asynchronous reset mid-RUN aborts without a done pulse
    d0 = done_cnt;
    drive_start(4'hB, 4'hD, 0);
    idle_cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_product", {24'b0, bus.product}, 32'd0);
    check("abort_busy",    {31'b0, bus.busy},    32'd0);
    check("abort_done",    {31'b0, bus.done},    32'd0);
    check("abort_state",   {30'b0, state_dbg},   32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(6);
    check("abort_no_done", done_cnt - d0, 32'd0);
    drive_start(4'hB, 4'hD, 1);
    wait_done("op_bxd", 4, 4);
    idle_cycles(1);

    // Zero operand
    drive_start(4'h0, 4'h9, 1);
    wait_done("op_0x9", ZERO_LAT, ZERO_BUSY);
    idle_cycles(1);

    // Random operands, some back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [3:0] mc, mp;
      mc = 4'($urandom_range(1, 15));
      mp = 4'($urandom_range(1, 15));
      drive_start(mc, mp, 1);
      wait_done("op_rand", 4, 4);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end

    idle_cycles(4);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_total", done_cnt, pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
